// File: rtl/div_defs.sv
// Shared definitions for the sequential restoring divider: FSM encodings and default widths.
package div_defs;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2
  } state_t;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, then trial-subtract the divisor.
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   i_pr,
  input  logic          i_bit,
  input  logic [VW-1:0] i_dvs,
  output logic [VW:0]   o_pr,
  output logic          o_q
);

  logic [VW+1:0] w_shift;
  logic [VW+1:0] w_dvs;
  logic [VW+1:0] w_diff;

  assign w_shift = {i_pr, i_bit};
  assign w_dvs   = (VW+2)'(i_dvs);
  assign w_diff  = w_shift - w_dvs;

  // A non-negative trial difference is the same as shifted >= divisor.
  assign o_q  = (w_shift >= w_dvs);
  assign o_pr = (VW+1)'(o_q ? w_diff : w_shift);

endmodule

// File: rtl/seq_booth_divider.sv
// Iterative radix-2 restoring divider with signed (truncating) and unsigned modes.
// state   | meaning
// S_IDLE  | waiting for start; results held
// S_CALC  | one quotient bit per cycle, MSB first, DW cycles
// S_FIXUP | apply signs, write results, pulse done
module seq_booth_divider
  import div_defs::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          tc,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz,
  output logic          ovf
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  state_t        r_state;
  state_t        w_next;
  logic          r_neg_q;
  logic          r_neg_r;
  logic          r_dbz_p;
  logic          r_ovf_p;
  logic [VW:0]   r_pr;
  logic [DW-1:0] r_dq;
  logic [VW-1:0] r_dvs;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic [DW-1:0] r_quot;
  logic [VW-1:0] r_rem;
  logic          r_dbz;
  logic          r_ovf;

  logic          w_accept;
  logic          w_last;
  logic          w_a_neg;
  logic          w_b_neg;
  logic [DW-1:0] w_a_mag;
  logic [VW-1:0] w_b_mag;
  logic [VW:0]   w_pr_next;
  logic          w_qbit;
  logic [DW-1:0] w_q_fix;
  logic [VW-1:0] w_r_fix;
  logic [VW-1:0] w_r_mag;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_cnt == CW'(DW - 1));
  assign w_a_neg  = tc & dividend[DW-1];
  assign w_b_neg  = tc & divisor[VW-1];
  // Negating the most negative dividend yields 2^(DW-1), which is still a valid unsigned magnitude.
  assign w_a_mag  = w_a_neg ? (~dividend + DW'(1)) : dividend;
  assign w_b_mag  = w_b_neg ? (~divisor + VW'(1)) : divisor;

  div_step #(.VW(VW)) u_step (
    .i_pr  (r_pr),
    .i_bit (r_dq[DW-1]),
    .i_dvs (r_dvs),
    .o_pr  (w_pr_next),
    .o_q   (w_qbit)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (w_last) w_next = S_FIXUP;
      S_FIXUP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_r_mag = VW'(r_pr);
    w_q_fix = r_neg_q ? (~r_dq + DW'(1)) : r_dq;
    w_r_fix = r_neg_r ? (~w_r_mag + VW'(1)) : w_r_mag;
    if (r_dbz_p) begin
      w_q_fix = '1;
      w_r_fix = '0;
    end else if (r_ovf_p) begin
      w_q_fix = {1'b1, {(DW-1){1'b0}}};
      w_r_fix = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz_p <= 1'b0;
      r_ovf_p <= 1'b0;
      r_pr    <= '0;
      r_dq    <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_FIXUP);
      if (w_accept) begin
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        r_dbz_p <= (divisor == '0);
        r_ovf_p <= tc && (dividend == {1'b1, {(DW-1){1'b0}}}) && (divisor == '1);
        r_pr    <= '0;
        r_dq    <= w_a_mag;
        r_dvs   <= w_b_mag;
        r_cnt   <= '0;
      end else if (r_state == S_CALC) begin
        r_pr  <= w_pr_next;
        r_dq  <= {r_dq[DW-2:0], w_qbit};
        r_cnt <= r_cnt + CW'(1);
      end else if (r_state == S_FIXUP) begin
        r_quot <= w_q_fix;
        r_rem  <= w_r_fix;
        r_dbz  <= r_dbz_p;
        r_ovf  <= r_ovf_p & ~r_dbz_p;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign dbz       = r_dbz;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_seq_booth_divider.sv
// Directed-vector bench for seq_booth_divider with a queue scoreboard checked on every done pulse.
module tb_seq_booth_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       tc = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       dbz;
  logic       ovf;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    logic       o;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   n_done = 0;

  seq_booth_divider #(.DW(8), .VW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .tc        (tc),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation");
      end else begin
        e = sb.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("dbz", 32'(dbz), 32'(e.z));
        chk("ovf", 32'(ovf), 32'(e.o));
        chk("busy_in_done_cycle", 32'(busy), 32'd0);
      end
    end
  end

  task automatic run_op(input logic t, input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] q, input logic [3:0] r,
                        input logic z, input logic o, input bit poke);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    @(negedge clk);
    tc       = t;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(exp_t'{q, r, z, o});
    @(posedge clk);
    #1;
    start    = 1'b0;
    tc       = ~t;
    dividend = ~a;
    divisor  = ~b;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat  = k;
      end else begin
        chk("busy_during_op", 32'(busy), 32'd1);
        if (poke && k == 4) start = 1'b1;
        if (poke && k == 5) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("done_latency", 32'(lat), 32'd10);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    rst_n = 1'b1;

    run_op(1'b1, 8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 1'b0, 1'b0);
    run_op(1'b1, 8'h9C, 4'd7, 8'hF2, 4'hE, 1'b0, 1'b0, 1'b0);
    run_op(1'b1, 8'd7, 4'hE, 8'hFD, 4'd1, 1'b0, 1'b0, 1'b0);
    run_op(1'b1, 8'h80, 4'hF, 8'h80, 4'd0, 1'b0, 1'b1, 1'b0);
    run_op(1'b0, 8'h80, 4'hF, 8'd8, 4'd8, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 1'b0, 1'b0);
    run_op(1'b1, 8'hFF, 4'hF, 8'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 8'h55, 4'd0, 8'hFF, 4'd0, 1'b1, 1'b0, 1'b1);

    // Abort an operation with reset between clock edges.
    @(negedge clk);
    tc       = 1'b1;
    dividend = 8'd100;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_dbz", 32'(dbz), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    run_op(1'b1, 8'd20, 4'd3, 8'd6, 4'd2, 1'b0, 1'b0, 1'b0);

    repeat (15) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("done_count", 32'(n_done), 32'd9);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule

// File: doc/seq_booth_divider.md
Name: seq_booth_divider

Overview:
- Iterative radix-2 restoring divider; the inverse operation of the team's 4x4 Booth multiplier.
- Takes an 8-bit dividend and a 4-bit divisor; returns an 8-bit quotient and a 4-bit remainder.
- Division truncates toward zero (C semantics) in two's-complement mode; plain unsigned mode is also supported.
- Sits beside the multiplier in the arithmetic datapath and uses a start/done handshake toward the issuing controller.

Parameters:
- DW, 8, dividend and quotient width.
- VW, 4, divisor and remainder width (VW <= DW).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- tc  in  1  1 = operands are two's complement; 0 = unsigned. Latched with start.
- dividend  in  DW  numerator; latched on the accepting edge.
- divisor  in  VW  denominator; latched on the accepting edge.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result outputs are valid from this cycle on.
- quotient  out  DW  result.
- remainder  out  VW  result; sign follows the dividend when tc=1.
- dbz  out  1  divide-by-zero flag for the last result.
- ovf  out  1  quotient overflow flag for the last result.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: busy=0, done=0, quotient=0, remainder=0, dbz=0, ovf=0, state=IDLE, all internal registers 0.
- Reset mid-operation: the in-flight operation is discarded immediately and no done is issued. After rst_n deasserts, the next start is accepted normally.

States:
- IDLE: on start=1 at edge E, latch tc and the operand signs, and latch the magnitudes |dividend| (DW bits unsigned; 128 is representable) and |divisor| (VW bits unsigned).
  - Clear the partial remainder (VW+1 bits) and set count=0.
  - Go to CALC; busy=1 after E.
- CALC: runs exactly DW cycles, taking one quotient bit per cycle, MSB first.
  - Shift left {partial remainder, dividend register}.
  - Trial-subtract |divisor| from the partial remainder.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - When count reaches DW-1, go to FIXUP.
- FIXUP: one cycle. Apply the sign rules (negation in DW/VW bits), write quotient, remainder, dbz and ovf, and pulse done. Return to IDLE.
  - quotient is negated when tc=1 and the operand signs differ.
  - remainder is negated when tc=1 and the dividend is negative.

Timing:
- done is high in the cycle following edge E+DW+1, i.e. DW+2 edges after acceptance.
- busy is high from E until the edge on which done rises; busy=0 in the done cycle.
- A new start may be accepted in the done cycle.
- start while busy=1 is ignored; no queuing.
- quotient, remainder, dbz and ovf hold their values until the next FIXUP.

Divisor = 0:
- The same latency still runs.
- Result: dbz=1, quotient = all ones, remainder = 0, ovf=0.

Overflow:
- Occurs only when tc=1, dividend = -2^(DW-1) and divisor = -1.
- Result: quotient = 2^(DW-1) bit pattern (0x80), remainder = 0, ovf=1.
- In all other cases ovf=0.

Unsigned mode (tc=0):
- No negation and no overflow.
- The remainder is always < divisor and fits in VW bits.

Decomposition:
- Shared package/include div_defs: state encodings S_IDLE, S_CALC, S_FIXUP (2-bit), and default widths DW_DEF=8 and VW_DEF=4.
- One natural sub-module, div_step: combinational restoring step. It takes the partial remainder, the next dividend bit and the divisor, and returns the next partial remainder and the quotient bit.
- The FSM, counter and sign fix-up stay in the top module.

Test Plan:
- tc=1, dividend=100, divisor=7 -> quotient=14, remainder=2, dbz=0, ovf=0; done exactly 10 cycles after the accepting edge, with busy high for the preceding 9 cycles.
- tc=1, -100 (0x9C) / 7 -> quotient=0xF2 (-14), remainder=0xE (-2). Also 7 / -2 (0xE) -> quotient=0xFD (-3), remainder=1.
- tc=1, 0x80 / 0xF -> quotient=0x80, remainder=0, ovf=1. Then tc=0, 0x80 / 0xF (128/15) -> quotient=8, remainder=8, ovf=0.
- tc=0, 255 / 15 -> quotient=17, remainder=0. Then tc=1, 0xFF / 0xF (-1/-1) -> quotient=1, remainder=0.
- divisor=0, dividend=0x55 -> after 10 cycles dbz=1, quotient=0xFF, remainder=0. A start pulsed mid-operation is ignored, and exactly one done is produced.
- Drive rst_n low at cycle 5 of an operation -> busy, done and all outputs go to 0 immediately with no clock edge. After release, start 20/3 (tc=1) -> quotient=6, remainder=2.
